// File: rtl/chi_stage_if.sv
// Bus bundle for chi_stage: start/done handshake, state-memory port and parity readout.
// slave = chi_stage side, master = sequencer/memory side.
interface chi_stage_if #(
  parameter int AW = 6,
  parameter int W  = 25
);
  logic          start;
  logic [W-1:0]  mem_rd_data;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wr_data;
  logic          busy;
  logic          done;
  logic [W-1:0]  parity_out;

  modport master (
    output start, mem_rd_data,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, busy, done, parity_out
  );

  modport slave (
    input  start, mem_rd_data,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, busy, done, parity_out
  );
endinterface

// File: rtl/chi_stage.sv
// chi row-mixing stage: walks all slices in place, read -> latch -> chi -> write per slice.
// Optional running parity of written slices when CHI_PARITY_EN is defined.
module chi_stage #(
  parameter int SLICES = 64,
  parameter int W      = 25
) (
  input logic        clk,
  input logic        rst,
  chi_stage_if.slave bus
);
  localparam int CW = $clog2(SLICES);

  typedef enum logic [2:0] {IDLE, READ, LATCH, COMPUTE, WRITE, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    in_reg;
  logic [W-1:0]    out_reg;
  logic            rd_en;
  logic            wr_en;
  logic            busy;
  logic            done;

  // Each row of five lanes is mixed independently; indices wrap mod 5 inside the row.
  function automatic logic [W-1:0] chi(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y+x] = a[5*y+x] ^ (~a[5*y+((x+1)%5)] & a[5*y+((x+2)%5)]);
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      in_reg  <= '0;
      out_reg <= '0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= READ;
            cnt   <= '0;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          in_reg <= bus.mem_rd_data;
          state  <= COMPUTE;
        end
        COMPUTE: begin
          out_reg <= chi(in_reg);
          wr_en   <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(SLICES - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rd_en <= 1'b1;
            state <= READ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_addr    = cnt;
  assign bus.mem_wr_data = out_reg;
  assign bus.busy        = busy;
  assign bus.done        = done;

`ifdef CHI_PARITY_EN
  logic [W-1:0] parity;

  // Cleared when a pass is accepted, held after done until the next pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= '0;
    end else if (state == IDLE && bus.start) begin
      parity <= '0;
    end else if (state == WRITE) begin
      parity <= parity ^ out_reg;
    end
  end

  assign bus.parity_out = parity;
`else
  assign bus.parity_out = '0;
`endif

endmodule
